// File: rtl/piso_shift_tx_pkg.sv
// rtl/piso_shift_tx_pkg.sv - shared types and helpers for the serial transmitter
//
// Package piso_pkg
//   piso_state_t : FSM state of the transmitter (IDLE, SHIFT)
//   cnt_width()  : bit-counter width for an N-bit word
package piso_pkg;

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} piso_state_t;

  // Width needed to count bit positions 0..n-1; never below 1.
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/piso_shift_tx_if.sv
// rtl/piso_shift_tx_if.sv - load port and serial bit stream of the transmitter
//
// Signals
//   d, load_valid, load_ready : parallel word load handshake
//   sout, svalid, sready      : serial bit stream handshake
//   done                      : one-cycle pulse after the last bit is accepted
// Modports
//   master : the transmitter itself
//   slave  : the producer/consumer side around it
interface piso_shift_tx_if #(
  parameter int N = 8
);

  logic [N-1:0] d;
  logic         load_valid;
  logic         load_ready;
  logic         sout;
  logic         svalid;
  logic         sready;
  logic         done;

  modport master (
    input  d, load_valid, sready,
    output load_ready, sout, svalid, done
  );

  modport slave (
    output d, load_valid, sready,
    input  load_ready, sout, svalid, done
  );

endinterface

// File: rtl/piso_shift_tx_bit_counter.sv
// rtl/piso_shift_tx_bit_counter.sv - clear/enable counter with terminal-count flag
//
// Ports
//   CLK   : clock
//   CLR   : synchronous active-high reset
//   clear : restart count at zero
//   en    : advance count by one
//   tc    : high while the count equals MAX
module bit_counter #(
  parameter int           W   = 3,
  parameter logic [W-1:0] MAX = '1
) (
  input  logic CLK,
  input  logic CLR,
  input  logic clear,
  input  logic en,
  output logic tc
);

  logic [W-1:0] cnt;

  always_ff @(posedge CLK) begin
    if (CLR || clear) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tc = (cnt == MAX);

endmodule

// File: rtl/piso_shift_tx.sv
// rtl/piso_shift_tx.sv - parallel-in serial-out transmitter with valid/ready bit stream
//
// Parameters
//   N         : word width (N >= 2)
//   MSB_FIRST : 1 sends d[N-1] first, 0 sends d[0] first
// Ports
//   CLK : clock, all state changes on the rising edge
//   CLR : synchronous active-high reset
//   bus : load port and serial stream (master side)
module piso_shift_tx
  import piso_pkg::*;
#(
  parameter int N         = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input logic            CLK,
  input logic            CLR,
  piso_shift_tx_if.master bus
);

  localparam int W = cnt_width(N);

  piso_state_t  state;
  logic [N-1:0] sr;
  logic [N-1:0] sr_next;
  logic         done_q;
  logic         load_fire;
  logic         bit_fire;
  logic         last_bit;

  assign load_fire = (state == IDLE) && bus.load_valid;
  assign bit_fire  = (state == SHIFT) && bus.sready;

  // Shift toward the output end, zero fill behind.
  assign sr_next = MSB_FIRST ? {sr[N-2:0], 1'b0} : {1'b0, sr[N-1:1]};

  // Counter stops at N-1; the next load restarts it, so it never wraps.
  bit_counter #(
    .W   (W),
    .MAX (W'(N - 1))
  ) u_bit_counter (
    .CLK   (CLK),
    .CLR   (CLR),
    .clear (load_fire),
    .en    (bit_fire && !last_bit),
    .tc    (last_bit)
  );

  always_ff @(posedge CLK) begin
    if (CLR) begin
      state  <= IDLE;
      sr     <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= bit_fire && last_bit;
      if (load_fire) begin
        sr    <= bus.d;
        state <= SHIFT;
      end else if (bit_fire) begin
        if (last_bit) begin
          state <= IDLE;
        end else begin
          sr <= sr_next;
        end
      end
    end
  end

  // Outputs depend on registered state only.
  assign bus.load_ready = (state == IDLE);
  assign bus.svalid     = (state == SHIFT);
  assign bus.sout       = MSB_FIRST ? sr[N-1] : sr[0];
  assign bus.done       = done_q;

endmodule

// File: tb/tb_piso_shift_tx.sv
// tb/tb_piso_shift_tx.sv - directed self-checking bench for piso_shift_tx
module tb_piso_shift_tx;

  logic CLK;
  logic CLR;
  int   n_checks = 0;
  int   n_errors = 0;

  piso_shift_tx_if #(.N(8)) bus_m ();
  piso_shift_tx_if #(.N(8)) bus_l ();

  piso_shift_tx #(.N(8), .MSB_FIRST(1'b1)) u_msb (.CLK(CLK), .CLR(CLR), .bus(bus_m));
  piso_shift_tx #(.N(8), .MSB_FIRST(1'b0)) u_lsb (.CLK(CLK), .CLR(CLR), .bus(bus_l));

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [7:0] dv, input logic lv, input logic rdy);
    bus_m.d = dv; bus_m.load_valid = lv; bus_m.sready = rdy;
    bus_l.d = dv; bus_l.load_valid = lv; bus_l.sready = rdy;
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, " load_ready_m"}, bus_m.load_ready, 1);
    check_eq({tag, " load_ready_l"}, bus_l.load_ready, 1);
    check_eq({tag, " svalid_m"}, bus_m.svalid, 0);
    check_eq({tag, " svalid_l"}, bus_l.svalid, 0);
    check_eq({tag, " sout_m"}, bus_m.sout, 0);
    check_eq({tag, " sout_l"}, bus_l.sout, 0);
    check_eq({tag, " done_m"}, bus_m.done, 0);
    check_eq({tag, " done_l"}, bus_l.done, 0);
  endtask

  // Sends nwords (1 or 2) words with load_valid held high until the last one is
  // taken. Entered and left at a falling edge with both DUTs idle. Streams are
  // returned first-bit-in-MSB.
  task automatic run_words(input string tag, input logic [7:0] w0, input logic [7:0] w1,
                           input int nwords, input bit bp,
                           output logic [7:0] s0m, output logic [7:0] s0l,
                           output logic [7:0] s1m, output logic [7:0] s1l);
    logic [7:0] cur, gm, gl, dval;
    int   loads, hs, done_words, last_load, ph;
    logic p_load, p_hs, p_hold, p_sm, p_sl, lv, rdy;
    bit   finished;
    cur = 0; gm = 0; gl = 0; loads = 0; hs = 0; done_words = 0; last_load = 0; ph = 0;
    s0m = 0; s0l = 0; s1m = 0; s1l = 0; finished = 0;
    lv = 1; rdy = 1;
    drive(w0, lv, rdy);
    p_load = bus_m.load_ready; p_hs = 0; p_hold = 0; p_sm = 0; p_sl = 0;
    for (int c = 1; c <= 200 && !finished; c++) begin
      @(negedge CLK);
      if (p_hs) hs++;
      if (p_load) begin
        loads++;
        cur = (loads == 1) ? w0 : w1;
        if (loads == 2 && !bp) check_eq({tag, " load_spacing"}, c - last_load, 9);
        last_load = c; hs = 0; gm = 0; gl = 0;
      end
      if (loads > done_words) begin
        if (hs == 8) begin
          check_eq({tag, " done_m"}, bus_m.done, 1);
          check_eq({tag, " done_l"}, bus_l.done, 1);
          check_eq({tag, " done_ready"}, bus_m.load_ready, 1);
          check_eq({tag, " done_svalid"}, bus_m.svalid, 0);
          if (done_words == 0) begin s0m = gm; s0l = gl; end
          else begin s1m = gm; s1l = gl; end
          done_words++;
        end else begin
          check_eq({tag, " svalid_m"}, bus_m.svalid, 1);
          check_eq({tag, " svalid_l"}, bus_l.svalid, 1);
          check_eq({tag, " busy_ready"}, bus_m.load_ready, 0);
          check_eq({tag, " busy_done"}, bus_m.done | bus_l.done, 0);
          check_eq({tag, " bit_m"}, bus_m.sout, cur[7 - hs]);
          check_eq({tag, " bit_l"}, bus_l.sout, cur[hs]);
          if (p_hold) begin
            check_eq({tag, " hold_m"}, bus_m.sout, p_sm);
            check_eq({tag, " hold_l"}, bus_l.sout, p_sl);
          end
          if (p_load || p_hs) begin
            gm = {gm[6:0], bus_m.sout};
            gl = {gl[6:0], bus_l.sout};
          end
        end
      end else begin
        check_eq({tag, " after_done"}, bus_m.done | bus_l.done, 0);
        check_eq({tag, " after_ready"}, bus_m.load_ready, 1);
        finished = 1;
      end
      lv   = (loads < nwords);
      dval = !lv ? 8'h00 : ((loads == 0) ? w0 : w1);
      rdy  = bp ? ((ph % 4 == 0) || (ph % 4 == 3)) : 1'b1;
      ph++;
      p_load = bus_m.load_ready && lv;
      p_hs   = bus_m.svalid && rdy;
      p_hold = bus_m.svalid && !rdy;
      p_sm   = bus_m.sout;
      p_sl   = bus_l.sout;
      drive(dval, lv, rdy);
    end
    if (!finished) check_eq({tag, " timeout"}, 0, 1);
    drive(8'h00, 0, 0);
  endtask

  logic [7:0] sm0, sl0, sm1, sl1;
  int         pulses;

  initial begin
    CLR = 1'b1;
    drive(8'h00, 0, 0);
    @(negedge CLK);
    @(negedge CLK);
    CLR = 1'b0;
    check_idle("reset");

    // Reset in the middle of a word: remaining bits dropped, no DONE.
    drive(8'hA5, 1, 1);
    @(negedge CLK);
    drive(8'h00, 0, 1);
    @(negedge CLK);
    @(negedge CLK);
    check_eq("pre_clr svalid", bus_m.svalid, 1);
    CLR = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    CLR = 1'b0;
    check_idle("mid_clr");
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge CLK);
      pulses += int'(bus_m.done) + int'(bus_l.done) + int'(bus_m.svalid);
    end
    check_eq("mid_clr no_done", pulses, 0);
    drive(8'h00, 0, 0);

    run_words("a5", 8'hA5, 8'h00, 1, 0, sm0, sl0, sm1, sl1);
    check_eq("a5 stream_m", sm0, 8'b1010_0101);
    check_eq("a5 stream_l", sl0, 8'b1010_0101);

    run_words("fd", 8'hFD, 8'h00, 1, 0, sm0, sl0, sm1, sl1);
    check_eq("fd stream_m", sm0, 8'b1111_1101);
    check_eq("fd stream_l", sl0, 8'b1011_1111);

    run_words("bp81", 8'h81, 8'h00, 1, 1, sm0, sl0, sm1, sl1);
    check_eq("bp81 stream_m", sm0, 8'b1000_0001);
    check_eq("bp81 stream_l", sl0, 8'b1000_0001);

    run_words("busy", 8'h0F, 8'hFF, 2, 0, sm0, sl0, sm1, sl1);
    check_eq("busy stream0_m", sm0, 8'b0000_1111);
    check_eq("busy stream0_l", sl0, 8'b1111_0000);
    check_eq("busy stream1_m", sm1, 8'b1111_1111);
    check_eq("busy stream1_l", sl1, 8'b1111_1111);

    run_words("b2b", 8'hA5, 8'h96, 2, 0, sm0, sl0, sm1, sl1);
    check_eq("b2b stream0_m", sm0, 8'b1010_0101);
    check_eq("b2b stream0_l", sl0, 8'b1010_0101);
    check_eq("b2b stream1_m", sm1, 8'b1001_0110);
    check_eq("b2b stream1_l", sl1, 8'b0110_1001);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/piso_shift_tx.md
# piso_shift_tx

Parallel-in, serial-out transmitter that takes an N-bit word (typically the signed product) in one parallel load and shifts it out one bit per handshake. It is the unloading end of the datapath: results captured by the parallel registers leave the block serially to a downstream consumer over a valid/ready bit stream. It has one clock domain and a single parallel-load port.

## Interface
- N, default 8: word width; legal range N ≥ 2.
- MSB_FIRST, default 1: 1 sends D[N-1] first; 0 sends D[0] first.

Ports:
- CLK, input, 1: clock; all state changes on the rising edge.
- CLR, input, 1: reset; synchronous, active-high. Sampled only on the rising edge of CLK.
- D, input, N: parallel word; sampled when LOAD_VALID & LOAD_READY.
- LOAD_VALID, input, 1: a word is present on D.
- LOAD_READY, output, 1: block can accept a word; high exactly when the state is IDLE.
- SOUT, output, 1: current serial bit.
- SVALID, output, 1: SOUT holds a valid bit; high exactly when the state is SHIFT.
- SREADY, input, 1: consumer accepts SOUT this cycle.
- DONE, output, 1: one-cycle pulse after the last bit of a word is accepted.

## Operation
- The block has two states, IDLE and SHIFT. It holds an N-bit shift register `sr` and a bit counter `cnt` of width $clog2(N).
- **Reset:** CLR = 1 at an edge forces:
  - state = IDLE, sr = 0, cnt = 0, DONE = 0;
  - which gives LOAD_READY = 1, SVALID = 0, SOUT = 0.
  - CLR overrides any load or handshake in the same cycle.
- **IDLE:**
  - LOAD_READY = 1.
  - On LOAD_VALID = 1: sr ← D, cnt ← 0, next state = SHIFT.
  - SREADY is ignored.
- **SHIFT:**
  - LOAD_READY = 0; LOAD_VALID is ignored and D is not sampled.
  - SOUT = sr[N-1] when MSB_FIRST = 1, otherwise sr[0].
  - On SVALID & SREADY:
    - if cnt = N-1: next state = IDLE and DONE ← 1 for the next cycle;
    - otherwise: sr shifts toward the output end (left when MSB_FIRST = 1, right when MSB_FIRST = 0), filling with 0, and cnt ← cnt + 1.
  - SREADY = 0 holds sr, cnt and SOUT unchanged, with no limit on duration.
- **DONE:** registered. It is 1 only in the single cycle following acceptance of bit N-1, and 0 otherwise.
- **Data handling:** no sign handling; bits are sent as raw two's-complement.
- **Reset mid-word:** CLR during SHIFT discards the remaining bits. No DONE pulse is produced for that word.

## Timing
- **Load to first bit:** a load accepted at edge k gives SVALID = 1 with the first bit on SOUT from edge k onward (visible in cycle k+1).
- **Word length:** with SREADY held at 1, bits 0 to N-1 occupy cycles k+1 to k+N.
- **Return to IDLE:** state is IDLE and DONE = 1 in cycle k+N+1.
- **Throughput:** minimum spacing between successive loads is N+1 cycles. There is one mandatory IDLE cycle, in which DONE = 1 and LOAD_READY = 1 coincide, so a new load can be accepted in that same cycle.
- **Timing paths:**
  - all outputs are functions of registered state only;
  - there is no combinational path from SREADY or LOAD_VALID to any output.
- **Counter:** cnt never wraps in normal operation, because it is compared against N-1 before incrementing.

## Structure
- Shared package `piso_pkg`:
  - `typedef enum logic {IDLE, SHIFT} piso_state_t`;
  - a function returning $clog2(N) for the counter width.
- Sub-module `bit_counter #(W, MAX)` provides a clear/enable counter with a terminal-count flag (cnt == MAX). Everything else lives in piso_shift_tx.

## Test plan
- **Reset:** assert CLR for 2 cycles during SHIFT → next cycle state IDLE, LOAD_READY = 1, SVALID = 0, SOUT = 0, DONE = 0.
- **MSB-first, full rate:** N = 8, MSB_FIRST = 1, load 8'hA5, SREADY = 1 → SOUT = 1,0,1,0,0,1,0,1 in cycles k+1 to k+8, DONE = 1 only in cycle k+9.
- **LSB-first, signed value:** MSB_FIRST = 0, load 8'hFD (−3) → SOUT = 1,0,1,1,1,1,1,1, then DONE.
- **Backpressure:** load 8'h81, SREADY toggling 1,0,0,1,…:
  - SOUT is stable while SREADY = 0;
  - exactly 8 handshakes occur, with bit order 1,0,0,0,0,0,0,1;
  - DONE follows the 8th handshake by 1 cycle.
- **Load while busy:** assert LOAD_VALID with D = 8'hFF during SHIFT of 8'h0F → no change to the output stream (0,0,0,0,1,1,1,1). Keeping LOAD_VALID high with D = 8'hFF into the DONE cycle loads 8'hFF there, and its first bit appears in the next cycle.
- **Back-to-back:** present two words with LOAD_VALID held high → loads occur exactly N+1 cycles apart, and a DONE pulse follows each word.
